// File: rtl/seq_match_pkg.sv
// Shared types and power-on configuration for the serial pattern detector.
package seq_match_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam int unsigned DEF_PATTERN = 'b1010;
  localparam int unsigned DEF_LEN     = 4;
  localparam logic        DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_match_shift.sv
// History shift register, fill counter and length-masked pattern compare.
// hit is combinational and only asserts on the cycle a qualified bit is shifted.
module seq_match_shift #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic               data_bit,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit,
  output logic               busy
);

  logic [PAT_MAX-1:0] hist, hist_n, mask;
  logic [LEN_W-1:0]   fill, fill_n;

  always_comb begin
    hist_n = {hist[PAT_MAX-2:0], data_bit};
    fill_n = (fill == LEN_W'(PAT_MAX)) ? fill : fill + 1'b1;
    mask   = '0;
    for (int i = 0; i < PAT_MAX; i++) mask[i] = (LEN_W'(i) < len);
    hit = shift && (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
  end

  assign busy = (fill != '0);

  // Clear wins over shift: a bit arriving as the detector is disabled still
  // produces its hit, but the history does not survive into the next session.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_n;
      fill <= (hit && !overlap) ? '0 : fill_n;
    end
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern detector: FSM, LED hold timer, match counter, config.
// Optional idle timeout that discards partial patterns: define SEQ_MATCH_TIMEOUT_EN.
module seq_match_ctrl
  import seq_match_pkg::*;
#(
  parameter int PAT_MAX     = 8,
  parameter int LEN_W       = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_cfg_we,
  input  logic [PAT_MAX-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_bit,
  input  logic               i_bit_valid,
  output logic               o_match,
  output logic               o_led,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_armed,
  output logic               o_cfg_err
);

  localparam int HW = $clog2(HOLD_CYC + 1);

  state_t             state, state_n;
  logic [HW-1:0]      hold_cnt, hold_n;
  logic [PAT_MAX-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               active, shift, hit, busy, timeout, clr_hist, cfg_ok;

  assign active   = (state != DISABLED);
  assign shift    = active && i_bit_valid;
  assign clr_hist = (active && !i_enable) || timeout;
  assign cfg_ok   = i_cfg_we && (state == DISABLED) &&
                    (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(PAT_MAX));

  seq_match_shift #(.PAT_MAX(PAT_MAX), .LEN_W(LEN_W)) u_shift (
    .clock    (i_clock),
    .reset    (i_reset),
    .clear    (clr_hist),
    .shift    (shift),
    .data_bit (i_bit),
    .pattern  (pattern),
    .len      (len),
    .overlap  (overlap),
    .hit      (hit),
    .busy     (busy)
  );

`ifdef SEQ_MATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle;

  assign timeout = active && busy && !i_bit_valid && (idle == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset || !active || !busy || i_bit_valid || timeout) idle <= '0;
    else                                                      idle <= idle + 1'b1;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = &{1'b0, busy, TIMEOUT_CYC[0]};
`endif

  // A match while lit reloads the timer so back-to-back matches keep the LED on.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    unique case (state)
      DISABLED: if (i_enable) state_n = ARMED;
      ARMED: if (hit) begin
        state_n = HOLD;
        hold_n  = HW'(HOLD_CYC);
      end
      HOLD: begin
        if (hit) hold_n = HW'(HOLD_CYC);
        else if (hold_cnt == HW'(1)) begin
          state_n = ARMED;
          hold_n  = '0;
        end else hold_n = hold_cnt - 1'b1;
      end
      default: state_n = DISABLED;
    endcase
    if (active && !i_enable) begin
      state_n = DISABLED;
      hold_n  = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= DISABLED;
      hold_cnt      <= '0;
      pattern       <= PAT_MAX'(DEF_PATTERN);
      len           <= LEN_W'(DEF_LEN);
      overlap       <= DEF_OVERLAP;
      o_match       <= 1'b0;
      o_cfg_err     <= 1'b0;
      o_match_count <= '0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      o_match   <= hit;
      o_cfg_err <= i_cfg_we && !cfg_ok;
      if (cfg_ok) begin
        pattern       <= i_cfg_pattern;
        len           <= i_cfg_len;
        overlap       <= i_cfg_overlap;
        o_match_count <= '0;
      end else if (hit && (o_match_count != '1)) begin
        o_match_count <= o_match_count + 1'b1;
      end
    end
  end

  assign o_led   = (state == HOLD);
  assign o_armed = active;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
// Two instances share stimulus; the second uses CNT_W=2 to exercise saturation.
module tb_seq_match_ctrl;

  localparam int HOLD_CYC    = 4;
  localparam int TIMEOUT_CYC = 16;

  typedef struct {
    bit         rst, en, we;
    logic [7:0] pat;
    logic [3:0] len;
    bit         ov, b, v;
  } stim_t;

  logic       clock = 1'b0;
  logic       reset, enable, cfg_we, cfg_overlap, bit_in, bit_valid;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       match, led, armed, cfg_err, match2, led2, armed2, cfg_err2;
  logic [7:0] count;
  logic [1:0] count2;
  logic [17:0] obs;

  seq_match_ctrl #(.PAT_MAX(8), .LEN_W(4), .CNT_W(8), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clock(clock), .i_reset(reset), .i_enable(enable), .i_cfg_we(cfg_we),
    .i_cfg_pattern(cfg_pattern), .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap),
    .i_bit(bit_in), .i_bit_valid(bit_valid), .o_match(match), .o_led(led),
    .o_match_count(count), .o_armed(armed), .o_cfg_err(cfg_err));

  seq_match_ctrl #(.PAT_MAX(8), .LEN_W(4), .CNT_W(2), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut2 (
    .i_clock(clock), .i_reset(reset), .i_enable(enable), .i_cfg_we(cfg_we),
    .i_cfg_pattern(cfg_pattern), .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap),
    .i_bit(bit_in), .i_bit_valid(bit_valid), .o_match(match2), .o_led(led2),
    .o_match_count(count2), .o_armed(armed2), .o_cfg_err(cfg_err2));

  always #5 clock = ~clock;

  assign obs = {match, led, armed, cfg_err, count, match2, led2, armed2, cfg_err2, count2};

  // Behavioural model: received bits since the last discard, newest at the back.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len, m_cnt, m_cnt2, m_led, m_idle;
  bit         m_ov, m_act, e_match, e_err;
  int         total = 0, bad = 0;

  function automatic logic [17:0] exp_vec();
    logic l;
    l = (m_led > 0);
    return {e_match, l, m_act, e_err, 8'(m_cnt), e_match, l, m_act, e_err, 2'(m_cnt2)};
  endfunction

  function automatic stim_t mk(bit rst, bit en, bit we, logic [7:0] pat, logic [3:0] len,
                               bit ov, bit b, bit v);
    stim_t s;
    s.rst = rst; s.en = en; s.we = we; s.pat = pat; s.len = len; s.ov = ov; s.b = b; s.v = v;
    return s;
  endfunction

  task automatic step(input stim_t s);
    bit ok;
    reset = s.rst; enable = s.en; cfg_we = s.we; cfg_pattern = s.pat; cfg_len = s.len;
    cfg_overlap = s.ov; bit_in = s.b; bit_valid = s.v;
    @(posedge clock);
    e_match = 0; e_err = 0;
    if (s.rst) begin
      mq.delete(); m_pat = 8'b1010; m_len = 4; m_ov = 1; m_act = 0;
      m_cnt = 0; m_cnt2 = 0; m_led = 0; m_idle = 0;
    end else begin
      if (s.we) begin
        if (!m_act && s.len >= 1 && s.len <= 8) begin
          m_pat = s.pat; m_len = int'(s.len); m_ov = s.ov; m_cnt = 0; m_cnt2 = 0;
        end else e_err = 1;
      end
      if (m_led > 0) m_led--;
      if (m_act && s.v) begin
        mq.push_back(s.b);
        if (mq.size() > 8) void'(mq.pop_front());
        m_idle = 0;
        if (mq.size() >= m_len) begin
          ok = 1;
          for (int i = 0; i < m_len; i++) if (mq[mq.size()-1-i] != m_pat[i]) ok = 0;
          if (ok) begin
            e_match = 1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            m_led = HOLD_CYC;
            if (!m_ov) mq.delete();
          end
        end
      end else if (m_act && mq.size() > 0) begin
`ifdef SEQ_MATCH_TIMEOUT_EN
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin mq.delete(); m_idle = 0; end
`endif
      end else m_idle = 0;
      if (m_act && !s.en) begin
        m_act = 0; mq.delete(); m_led = 0; m_idle = 0;
      end else if (!m_act && s.en) m_act = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL reset cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    total++;
    if (obs !== 18'h0) begin bad++; $display("FAIL reset_zero: got %h want 0", obs); end
  endtask

  task automatic test_overlap();
    stim_t s[$];
    logic [5:0] bits = 6'b101010;
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 5; i >= 0; i--) s.push_back(mk(0, 1, 0, 0, 0, 0, bits[i], 1));
    repeat (6) s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL overlap cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    total++;
    if (count !== 8'd2) begin bad++; $display("FAIL overlap_count: got %0d want 2", count); end
  endtask

  task automatic test_nonoverlap();
    stim_t s[$];
    logic [5:0] bits = 6'b101010;
    s.push_back(mk(0, 0, 1, 8'b1010, 4, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 5; i >= 0; i--) s.push_back(mk(0, 1, 0, 0, 0, 0, bits[i], 1));
    repeat (6) s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL nonoverlap cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    total++;
    if (count !== 8'd1) begin bad++; $display("FAIL nonoverlap_count: got %0d want 1", count); end
  endtask

  task automatic test_cfg_err();
    stim_t s[$];
    logic [3:0] bits = 4'b1010;
    s.push_back(mk(0, 0, 1, 8'b1010, 4, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 1, 8'b111, 3, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 3; i >= 0; i--) s.push_back(mk(0, 1, 0, 0, 0, 0, bits[i], 1));
    repeat (5) s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 8'b1, 0, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 8'b1, 9, 1, 0, 0));
    s.push_back(mk(0, 0, 1, 8'hA5, 8, 1, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL cfg_err cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_disable_clear();
    stim_t s[$];
    // Enable rising together with a write: the write still lands.
    s.push_back(mk(0, 1, 1, 8'b1010, 4, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    // Completing bit on the same cycle enable drops: match still pulses.
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    repeat (3) s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL disable cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_saturate();
    stim_t s[$];
    s.push_back(mk(0, 1, 1, 8'b1, 1, 1, 0, 0));
    repeat (5) s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    repeat (5) s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL saturate cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    total++;
    if (count2 !== 2'd3 || count !== 8'd5) begin
      bad++; $display("FAIL saturate_final: got %0d/%0d want 5/3", count, count2);
    end
  endtask

  task automatic test_timeout();
    stim_t s[$];
    s.push_back(mk(0, 1, 1, 8'b1010, 4, 1, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    repeat (TIMEOUT_CYC) s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    repeat (5) s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL timeout cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid_hold();
    stim_t s[$];
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      step(s[i]);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL reset_hold cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    bit en = 0;
    stim_t st;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      st = mk($urandom_range(0, 149) == 0, en, $urandom_range(0, 14) == 0,
              8'($urandom), 4'($urandom_range(0, 5)), 1'($urandom),
              1'($urandom), $urandom_range(0, 2) != 0);
      if (st.we && $urandom_range(0, 3) == 0) st.len = 4'($urandom);
      step(st);
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  initial begin
    reset = 1; enable = 0; cfg_we = 0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 0; bit_in = 0; bit_valid = 0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_cfg_err();
    test_disable_clear();
    test_saturate();
    test_timeout();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Controller for a programmable serial pattern detector on the button/LED path.
- Accepts a run-time pattern, length and overlap mode while disabled.
- Shifts in qualified serial bits and flags matches.
- Drives an LED for a fixed hold time on each match and keeps a saturating match counter.
- Sits between the button sampling logic (bit/valid strobe) and the board LED. It replaces hard-wired, single-pattern detectors.

Parameters:
- PAT_MAX, 8: maximum pattern length in bits.
- LEN_W, 4: width of the length field; must hold PAT_MAX.
- CNT_W, 8: match counter width.
- HOLD_CYC, 4: LED hold time in clocks per match; must be >= 1.
- TIMEOUT_CYC, 16: idle-gap limit in clocks; used only with the optional feature.

Ports:
- i_clock, input, 1: clock; all logic on the rising edge.
- i_reset, input, 1: synchronous reset, active-high.
- i_enable, input, 1: 1 = detect; 0 = disabled and configurable.
- i_cfg_we, input, 1: configuration write strobe.
- i_cfg_pattern, input, PAT_MAX: pattern; bit[len-1] is the oldest bit, bit[0] the newest.
- i_cfg_len, input, LEN_W: pattern length; legal range 1..PAT_MAX.
- i_cfg_overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- i_bit, input, 1: serial data bit.
- i_bit_valid, input, 1: qualifies i_bit for one clock.
- o_match, output, 1: one-cycle match pulse.
- o_led, output, 1: LED drive.
- o_match_count, output, CNT_W: saturating match count.
- o_armed, output, 1: high in states ARMED and HOLD.
- o_cfg_err, output, 1: one-cycle pulse when a configuration write is rejected.

Behaviour:
- Reset values:
  - state DISABLED; history 0; fill 0; hold counter 0.
  - pattern = 'b1010, len = 4, overlap = 1.
  - All outputs 0; count 0.
- States:
  - DISABLED: no detection; configuration writes allowed.
  - ARMED: detecting.
  - HOLD: detecting, LED lit.
- Transitions:
  - DISABLED -> ARMED when i_enable = 1.
  - ARMED -> HOLD on a match.
  - HOLD -> ARMED when the hold counter expires.
  - ARMED or HOLD -> DISABLED when i_enable = 0, taking effect the next cycle.
- On entry to DISABLED: clear history, fill, hold counter and o_led. Keep the count.
- Shift rule, applied in ARMED or HOLD when i_bit_valid = 1:
  - hist_n = {hist[PAT_MAX-2:0], i_bit}.
  - fill_n = min(fill+1, PAT_MAX).
- Match condition: fill_n >= len and hist_n[len-1:0] == pattern[len-1:0].
- Match timing: o_match is registered and goes high the cycle after the completing valid bit.
- Overlap handling on a match:
  - overlap = 1: fill continues.
  - overlap = 0: fill is forced to 0, so the bit that completed the match is not reused.
- Hold: o_led = 1 exactly HOLD_CYC cycles, starting the same cycle as o_match. A match during HOLD reloads the counter to HOLD_CYC, so the LED stays continuously lit.
- Counter: increments on each match; saturates at all-ones with no wrap.
- Configuration write (i_cfg_we = 1):
  - Accepted only in DISABLED with 1 <= i_cfg_len <= PAT_MAX.
  - Accepted: latch pattern, len and overlap; clear the count.
  - Otherwise: ignore the write and pulse o_cfg_err the next cycle.
- Simultaneous events:
  - i_enable rise and i_cfg_we in the same cycle: the write is accepted, since state is still DISABLED.
  - i_enable fall and a valid bit in the same cycle: the bit is processed; any match still pulses.
- Reset mid-HOLD: o_led drops the next cycle.

Optional Feature:
- Macro: SEQ_MATCH_TIMEOUT_EN.
- Defined:
  - An idle counter runs in ARMED/HOLD while fill > 0.
  - Each i_bit_valid clears it.
  - Reaching TIMEOUT_CYC clears history and fill, so a partial pattern is discarded. The hold and count are unaffected.
- Undefined: no idle counter; a partial pattern is kept indefinitely.

Decomposition:
- Package seq_match_pkg holds:
  - state enum {DISABLED, ARMED, HOLD};
  - default pattern constant 'b1010, default len 4, default overlap 1.
- One natural sub-module: seq_match_shift. It contains the history register, fill counter and masked compare, and outputs a combinational hit. The controller FSM, hold timer, counter and configuration logic stay in the top module.

Test Plan:
1. Defaults (pattern 1010, len 4, overlap 1); enable; bits 1,0,1,0,1,0, each with valid -> o_match after the 4th and 6th bits; count = 2; o_led high for 4 cycles after each match, merged into one continuous high.
2. Write overlap = 0 while disabled; enable; same stream -> one match after the 4th bit; count = 1.
3. Write pattern 'b111, len 3 while enabled -> o_cfg_err pulses; the config stays 1010. Write len 0 while disabled -> o_cfg_err pulses.
4. Enable, send 1,0,1, drop i_enable, re-enable, send 0 -> no match, because history was cleared.
5. CNT_W = 2; produce 5 matches -> count sticks at 3.
6. With SEQ_MATCH_TIMEOUT_EN: send 1,0,1, idle 16 cycles, send 0 -> no match. Without the macro, the same stimulus -> match.
